// File: rtl/fir_tap_arbiter.sv
// fir_tap_arbiter: shares the single-port tap BRAM between the host and the FIR engine,
// with engine priority, bounded host starvation, a busy write lockout and index range protection.
module fir_tap_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int STARVE_LIM  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   h_req,
  input  logic                   h_we,
  input  logic [3:0]             h_idx,
  input  logic [pDATA_WIDTH-1:0] h_wdata,
  output logic                   h_gnt,
  output logic                   h_rvalid,
  output logic [pDATA_WIDTH-1:0] h_rdata,
  output logic                   h_err,
  input  logic                   engine_busy,
  input  logic                   e_req,
  input  logic [3:0]             e_idx,
  output logic                   e_gnt,
  output logic                   e_rvalid,
  output logic [pDATA_WIDTH-1:0] e_rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);
  localparam logic [4:0] NT = 5'(Tape_Num);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] SL = SW'(STARVE_LIM);
  logic [SW-1:0] r_starve;
  logic r_h_rv, r_h_oor, r_h_err, r_e_rv, r_e_oor;
  logic w_h_oor, w_e_oor, w_h_elig, w_e_in, w_force, w_h_bram, w_e_bram;
  assign w_h_oor  = {1'b0, h_idx} >= NT;
  assign w_e_oor  = {1'b0, e_idx} >= NT;
  // host writes are not eligible while the engine runs, so they neither win nor starve
  assign w_h_elig = h_req & ~w_h_oor & (~h_we | ~engine_busy);
  assign w_e_in   = e_req & ~w_e_oor;
  assign w_force  = w_h_elig & (r_starve == SL);
  assign w_h_bram = axis_rst_n & w_h_elig & (~w_e_in | w_force);
  assign w_e_bram = axis_rst_n & w_e_in & ~w_force;
  assign h_gnt    = w_h_bram | (axis_rst_n & h_req & w_h_oor);
  assign e_gnt    = w_e_bram | (axis_rst_n & e_req & w_e_oor);
  assign tap_EN   = w_h_bram | w_e_bram;
  assign tap_WE   = (w_h_bram & h_we) ? 4'hF : 4'h0;
  assign tap_Di   = (w_h_bram & h_we) ? h_wdata : '0;
  assign tap_A    = w_h_bram ? pADDR_WIDTH'({h_idx, 2'b00})
                  : w_e_bram ? pADDR_WIDTH'({e_idx, 2'b00}) : '0;
  assign h_rvalid = r_h_rv;
  assign h_rdata  = (r_h_rv & ~r_h_oor) ? tap_Do : '0;
  assign h_err    = r_h_err;
  assign e_rvalid = r_e_rv;
  assign e_rdata  = (r_e_rv & ~r_e_oor) ? tap_Do : '0;
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      r_starve <= '0;
      r_h_rv   <= 1'b0;
      r_h_oor  <= 1'b0;
      r_h_err  <= 1'b0;
      r_e_rv   <= 1'b0;
      r_e_oor  <= 1'b0;
    end else begin
      r_starve <= (!h_req || h_gnt) ? '0 : (w_h_elig && r_starve != SL) ? r_starve + 1'b1 : r_starve;
      r_h_rv   <= h_gnt & ~h_we;
      r_h_oor  <= w_h_oor;
      r_h_err  <= h_gnt & w_h_oor;
      r_e_rv   <= e_gnt;
      r_e_oor  <= w_e_oor;
    end
  end
endmodule

// File: tb/tb_fir_tap_arbiter.sv
// tb_fir_tap_arbiter: directed stimulus with a read-return scoreboard and a behavioural tap BRAM.
module tb_fir_tap_arbiter;
  logic clk = 1'b0;
  logic rst_n, h_req, h_we, engine_busy, e_req;
  logic [3:0] h_idx, e_idx;
  logic [31:0] h_wdata;
  logic h_gnt, h_rvalid, h_err, e_gnt, e_rvalid, tap_EN;
  logic [31:0] h_rdata, e_rdata, tap_Di, tap_Do;
  logic [3:0] tap_WE;
  logic [11:0] tap_A;
  typedef struct packed { logic [31:0] data; logic err; } exp_t;
  exp_t h_q[$];
  exp_t e_q[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] mem [16] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107,
                            32'h108, 32'h109, 32'h10A, 32'h10B, 32'h10C, 32'h10D, 32'h10E, 32'h10F};
  // coefficients expected after the host writes idx 3 = 7 and idx 4 = 0xABCD
  logic [31:0] burst_exp [11] = '{32'h100, 32'h101, 32'h102, 32'h7, 32'hABCD, 32'h105,
                                  32'h106, 32'h107, 32'h108, 32'h109, 32'h10A};

  always #5 clk = ~clk;

  fir_tap_arbiter dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .h_req(h_req), .h_we(h_we), .h_idx(h_idx), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_err(h_err),
    .engine_busy(engine_busy), .e_req(e_req), .e_idx(e_idx),
    .e_gnt(e_gnt), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
    .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do)
  );

  always @(posedge clk) begin
    if (tap_EN) begin
      if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
      tap_Do <= mem[tap_A[5:2]];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (h_rvalid === 1'b1) begin
      if (h_q.size() == 0) chk("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
      else begin
        x = h_q.pop_front();
        chk("h_rdata", h_rdata, x.data);
        chk("h_err", 32'(h_err), 32'(x.err));
      end
    end else if (h_err === 1'b1) chk("h_err_stray", 32'(h_err), 32'd0);
    if (e_rvalid === 1'b1) begin
      if (e_q.size() == 0) chk("e_rvalid_unexpected", 32'(e_rvalid), 32'd0);
      else begin
        x = e_q.pop_front();
        chk("e_rdata", e_rdata, x.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; h_req = 1'b1; h_we = 1'b0; h_idx = 4'd1; h_wdata = '0;
    engine_busy = 1'b0; e_req = 1'b1; e_idx = 4'd2;
    @(negedge clk);
    chk("rst_h_gnt", 32'(h_gnt), 32'd0);
    chk("rst_e_gnt", 32'(e_gnt), 32'd0);
    chk("rst_tap_EN", 32'(tap_EN), 32'd0);
    chk("rst_tap_A", 32'(tap_A), 32'd0);
    tick();
    rst_n = 1'b1; h_req = 1'b0; e_req = 1'b0;
    @(negedge clk);
    chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("rst_e_rvalid", 32'(e_rvalid), 32'd0);
    chk("rst_h_err", 32'(h_err), 32'd0);
    // host write idx 3 then read it back
    tick();
    h_req = 1'b1; h_we = 1'b1; h_idx = 4'd3; h_wdata = 32'h7;
    @(negedge clk);
    chk("wr_h_gnt", 32'(h_gnt), 32'd1);
    chk("wr_tap_WE", 32'(tap_WE), 32'hF);
    chk("wr_tap_A", 32'(tap_A), 32'h00C);
    chk("wr_tap_Di", tap_Di, 32'h7);
    tick();
    h_we = 1'b0;
    h_q.push_back('{data: 32'h7, err: 1'b0});
    @(negedge clk);
    chk("rd_h_gnt", 32'(h_gnt), 32'd1);
    chk("rd_tap_WE", 32'(tap_WE), 32'd0);
    tick();
    h_req = 1'b0;
    // write lockout while the engine is busy
    tick();
    engine_busy = 1'b1; h_req = 1'b1; h_we = 1'b1; h_idx = 4'd4; h_wdata = 32'hABCD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("lock_h_gnt", 32'(h_gnt), 32'd0);
      chk("lock_tap_WE", 32'(tap_WE), 32'd0);
      tick();
    end
    engine_busy = 1'b0;
    @(negedge clk);
    chk("unlock_h_gnt", 32'(h_gnt), 32'd1);
    chk("unlock_tap_WE", 32'(tap_WE), 32'hF);
    tick();
    h_req = 1'b0; h_we = 1'b0;
    // starvation bound: engine wins 4 cycles, host forced on the 5th
    tick();
    e_req = 1'b1; e_idx = 4'd1; h_req = 1'b1; h_idx = 4'd5;
    for (int i = 0; i < 4; i++) begin
      e_q.push_back('{data: 32'h101, err: 1'b0});
      @(negedge clk);
      chk("starve_e_gnt", 32'(e_gnt), 32'd1);
      chk("starve_h_gnt", 32'(h_gnt), 32'd0);
      tick();
    end
    h_q.push_back('{data: 32'h105, err: 1'b0});
    @(negedge clk);
    chk("forced_h_gnt", 32'(h_gnt), 32'd1);
    chk("forced_e_gnt", 32'(e_gnt), 32'd0);
    chk("forced_tap_A", 32'(tap_A), 32'h014);
    tick();
    h_req = 1'b0;
    e_q.push_back('{data: 32'h101, err: 1'b0});
    @(negedge clk);
    chk("resume_e_gnt", 32'(e_gnt), 32'd1);
    tick();
    e_req = 1'b0;
    // out-of-range host read concurrent with engine read of idx 0
    tick();
    h_req = 1'b1; h_we = 1'b0; h_idx = 4'd12; e_req = 1'b1; e_idx = 4'd0;
    h_q.push_back('{data: 32'h0, err: 1'b1});
    e_q.push_back('{data: 32'h100, err: 1'b0});
    @(negedge clk);
    chk("oor_h_gnt", 32'(h_gnt), 32'd1);
    chk("oor_e_gnt", 32'(e_gnt), 32'd1);
    chk("oor_tap_A", 32'(tap_A), 32'd0);
    tick();
    h_req = 1'b0; e_req = 1'b0;
    // reset right after an engine read grant
    tick();
    e_req = 1'b1; e_idx = 4'd2;
    e_q.push_back('{data: 32'h102, err: 1'b0});
    @(negedge clk);
    chk("pre_rst_e_gnt", 32'(e_gnt), 32'd1);
    tick();
    rst_n = 1'b0; h_req = 1'b1; h_idx = 4'd6;
    @(negedge clk);
    chk("in_rst_e_gnt", 32'(e_gnt), 32'd0);
    chk("in_rst_h_gnt", 32'(h_gnt), 32'd0);
    tick();
    @(negedge clk);
    chk("in_rst_e_rvalid", 32'(e_rvalid), 32'd0);
    chk("in_rst_e_gnt2", 32'(e_gnt), 32'd0);
    tick();
    rst_n = 1'b1; h_req = 1'b0; e_req = 1'b0;
    @(negedge clk);
    chk("post_rst_e_rvalid", 32'(e_rvalid), 32'd0);
    // engine burst over all taps
    tick();
    for (int i = 0; i < 11; i++) begin
      e_req = 1'b1; e_idx = 4'(i);
      e_q.push_back('{data: burst_exp[i], err: 1'b0});
      @(negedge clk);
      chk("burst_e_gnt", 32'(e_gnt), 32'd1);
      tick();
    end
    e_req = 1'b0;
    repeat (3) tick();
    chk("h_q_drained", 32'(h_q.size()), 32'd0);
    chk("e_q_drained", 32'(e_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
